// File: rtl/uart_receiver.sv
// ---------------------------------------------------------------------------
// uart_receiver
//
// Serial-to-parallel UART receiver. The asynchronous line i_rx is brought
// into the i_clock domain through a two-flop synchronizer and oversampled
// with the shared 16x baud tick. A falling edge starts a frame; the start bit
// is confirmed at its centre (8 ticks in), each data bit is then sampled at
// its centre (every 16 ticks, LSB first), and the stop bit is sampled after
// SB_TICK further ticks. The received word is presented on o_data with a
// one-cycle o_rx_done strobe, and o_frame_err reports a low stop-bit sample.
//
// Parameters
//   D_BIT    data bits per frame (5..8)
//   SB_TICK  ticks per stop bit (16 = 1, 24 = 1.5, 32 = 2 stop bits)
//
// Ports
//   i_clock      in   1      system clock, rising edge
//   i_reset      in   1      synchronous, active-high reset
//   i_s_tick     in   1      1-cycle strobe, 16 per bit period
//   i_rx         in   1      asynchronous serial line, idle high
//   o_rx_done    out  1      1-cycle pulse: new word on o_data
//   o_data       out  D_BIT  last received word, held until next o_rx_done
//   o_frame_err  out  1      stop-bit sample of last word was 0
// ---------------------------------------------------------------------------
module uart_receiver #(
  parameter int D_BIT   = 8,
  parameter int SB_TICK = 16
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_s_tick,
  input  logic             i_rx,
  output logic             o_rx_done,
  output logic [D_BIT-1:0] o_data,
  output logic             o_frame_err
);

  // Tick counter must reach both 15 (data bit length) and SB_TICK-1.
  localparam int S_MAX = (SB_TICK > 16) ? SB_TICK : 16;
  localparam int S_W   = $clog2(S_MAX);
  localparam int N_W   = (D_BIT > 1) ? $clog2(D_BIT) : 1;

  localparam logic [S_W-1:0] S_START_MID = S_W'(7);
  localparam logic [S_W-1:0] S_BIT_LAST  = S_W'(15);
  localparam logic [S_W-1:0] S_STOP_LAST = S_W'(SB_TICK - 1);
  localparam logic [N_W-1:0] N_LAST      = N_W'(D_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // Synchronizer flops
  logic             rx_meta_q, rx_meta_d;
  logic             rx_sync_q, rx_sync_d;
  logic             rx_s;

  // Receive FSM and datapath
  state_t           state_q, state_d;
  logic [S_W-1:0]   s_q, s_d;
  logic [N_W-1:0]   n_q, n_d;
  logic [D_BIT-1:0] shift_q, shift_d;

  // Output registers
  logic             done_q, done_d;
  logic [D_BIT-1:0] data_q, data_d;
  logic             ferr_q, ferr_d;

  assign rx_s = rx_sync_q;

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      // Synchronizer resets to the idle line level so reset itself never
      // looks like a start edge.
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      state_q   <= IDLE;
      s_q       <= '0;
      n_q       <= '0;
      shift_q   <= '0;
      done_q    <= 1'b0;
      data_q    <= '0;
      ferr_q    <= 1'b0;
    end else begin
      rx_meta_q <= rx_meta_d;
      rx_sync_q <= rx_sync_d;
      state_q   <= state_d;
      s_q       <= s_d;
      n_q       <= n_d;
      shift_q   <= shift_d;
      done_q    <= done_d;
      data_q    <= data_d;
      ferr_q    <= ferr_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and output logic
  // -------------------------------------------------------------------------
  always_comb begin
    rx_meta_d = i_rx;
    rx_sync_d = rx_meta_q;
    state_d   = state_q;
    s_d       = s_q;
    n_d       = n_q;
    shift_d   = shift_q;
    done_d    = 1'b0;
    data_d    = data_q;
    ferr_d    = ferr_q;

    case (state_q)
      IDLE: begin
        // Start edge detection does not wait for a tick; the tick counter
        // then measures from the first tick after the edge.
        if (!rx_s) begin
          state_d = START;
          s_d     = '0;
        end
      end

      START: begin
        if (i_s_tick) begin
          if (s_q == S_START_MID) begin
            if (!rx_s) begin
              // Still low at the start-bit centre: a real frame.
              state_d = DATA;
              s_d     = '0;
              n_d     = '0;
            end else begin
              // Line went back high: treat as a glitch and drop it silently.
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end

      DATA: begin
        if (i_s_tick) begin
          if (s_q == S_BIT_LAST) begin
            s_d     = '0;
            // LSB arrives first, so shift in from the top.
            shift_d = {rx_s, shift_q[D_BIT-1:1]};
            if (n_q == N_LAST) begin
              state_d = STOP;
            end else begin
              n_d = n_q + N_W'(1);
            end
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end

      STOP: begin
        if (i_s_tick) begin
          if (s_q == S_STOP_LAST) begin
            // The word is delivered even with a bad stop bit; the error flag
            // travels with it. Returning to IDLE here lets a back-to-back
            // start bit be picked up immediately.
            state_d = IDLE;
            s_d     = '0;
            done_d  = 1'b1;
            data_d  = shift_q;
            ferr_d  = ~rx_s;
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
        s_d     = '0;
      end
    endcase
  end

  assign o_rx_done   = done_q;
  assign o_data      = data_q;
  assign o_frame_err = ferr_q;

endmodule

// File: tb/tb_uart_receiver.sv
// ---------------------------------------------------------------------------
// tb_uart_receiver
//
// Directed bench for uart_receiver (D_BIT=8, SB_TICK=16). A baud tick is
// produced every 4 clocks, so one bit period is 64 clocks. Frames are driven
// bit by bit on the falling clock edge; a monitor records every o_rx_done
// pulse together with the word and error flag delivered with it.
// ---------------------------------------------------------------------------
module tb_uart_receiver;

  localparam int BIT_CLKS = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       rx;
  logic       done;
  logic [7:0] data;
  logic       ferr;

  int checks = 0;
  int errors = 0;

  // Monitor state
  int         pulse_cnt = 0;
  logic [7:0] last_data = '0;
  logic       last_err  = 1'b0;
  logic       prev_done = 1'b0;
  int         dbl_cnt   = 0;
  logic       in_break  = 1'b0;
  int         break_cnt = 0;
  int         break_bad = 0;

  int         base_cnt;

  uart_receiver #(
    .D_BIT   (8),
    .SB_TICK (16)
  ) dut (
    .i_clock     (clk),
    .i_reset     (rst),
    .i_s_tick    (tick),
    .i_rx        (rx),
    .o_rx_done   (done),
    .o_data      (data),
    .o_frame_err (ferr)
  );

  always #5 clk = ~clk;

  // Baud tick: one cycle high out of every four.
  initial begin
    tick = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (done) begin
      pulse_cnt <= pulse_cnt + 1;
      last_data <= data;
      last_err  <= ferr;
      if (in_break) begin
        break_cnt <= break_cnt + 1;
        if (data !== 8'h00 || ferr !== 1'b1) break_bad <= break_bad + 1;
      end
    end
    if (done && prev_done) dbl_cnt <= dbl_cnt + 1;
    prev_done <= done;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic hold_line(input logic lvl, input int clks);
    rx = lvl;
    repeat (clks) @(negedge clk);
  endtask

  // Start bit, 8 data bits LSB first, one stop bit of the given level.
  task automatic send_frame(input logic [7:0] b, input logic stop_lvl);
    hold_line(1'b0, BIT_CLKS);
    for (int i = 0; i < 8; i++) hold_line(b[i], BIT_CLKS);
    hold_line(stop_lvl, BIT_CLKS);
  endtask

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    repeat (5) @(negedge clk);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_data", {24'd0, data}, 32'h00);
    check("reset_ferr", {31'd0, ferr}, 32'd0);
    rst = 1'b0;
    hold_line(1'b1, 2 * BIT_CLKS);
    check("idle_no_pulse", pulse_cnt, 0);

    // T1: single 8N1 frame
    send_frame(8'hA5, 1'b1);
    hold_line(1'b1, BIT_CLKS);
    check("t1_count", pulse_cnt, 1);
    check("t1_data", {24'd0, last_data}, 32'hA5);
    check("t1_ferr", {31'd0, last_err}, 32'd0);
    check("t1_out_held", {24'd0, data}, 32'hA5);

    // T2: back-to-back frames, no idle gap
    send_frame(8'h00, 1'b1);
    check("t2a_count", pulse_cnt, 2);
    check("t2a_data", {24'd0, last_data}, 32'h00);
    check("t2a_ferr", {31'd0, last_err}, 32'd0);
    send_frame(8'hFF, 1'b1);
    hold_line(1'b1, BIT_CLKS);
    check("t2b_count", pulse_cnt, 3);
    check("t2b_data", {24'd0, last_data}, 32'hFF);
    check("t2b_ferr", {31'd0, last_err}, 32'd0);

    // T3: 5-tick low glitch is rejected
    hold_line(1'b0, 5 * 4);
    hold_line(1'b1, 3 * BIT_CLKS);
    check("t3_count", pulse_cnt, 3);
    check("t3_data", {24'd0, data}, 32'hFF);

    // T4: stop bit forced low, then a clean frame
    send_frame(8'h3C, 1'b0);
    hold_line(1'b1, BIT_CLKS);
    check("t4a_count", pulse_cnt, 4);
    check("t4a_data", {24'd0, last_data}, 32'h3C);
    check("t4a_ferr", {31'd0, last_err}, 32'd1);
    check("t4a_ferr_held", {31'd0, ferr}, 32'd1);
    send_frame(8'h12, 1'b1);
    hold_line(1'b1, BIT_CLKS);
    check("t4b_count", pulse_cnt, 5);
    check("t4b_data", {24'd0, last_data}, 32'h12);
    check("t4b_ferr", {31'd0, last_err}, 32'd0);

    // T5: reset in the middle of data bit 4 of 0x55, then 0x81
    hold_line(1'b0, BIT_CLKS);
    for (int i = 0; i < 4; i++) hold_line(1'(8'h55 >> i), BIT_CLKS);
    hold_line(1'b1, BIT_CLKS / 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_rst_data", {24'd0, data}, 32'h00);
    check("t5_rst_ferr", {31'd0, ferr}, 32'd0);
    check("t5_rst_done", {31'd0, done}, 32'd0);
    hold_line(1'b1, 2 * BIT_CLKS);
    check("t5_no_pulse", pulse_cnt, 5);
    send_frame(8'h81, 1'b1);
    hold_line(1'b1, BIT_CLKS);
    check("t5_count", pulse_cnt, 6);
    check("t5_data", {24'd0, last_data}, 32'h81);
    check("t5_ferr", {31'd0, last_err}, 32'd0);

    // T6: break held low for 25 bit times
    in_break = 1'b1;
    hold_line(1'b0, 25 * BIT_CLKS);
    in_break = 1'b0;
    check("t6_break_reports", break_cnt, 2);
    check("t6_break_content", break_bad, 0);
    check("t6_break_total", pulse_cnt, 8);
    // The frame in flight at release sees a high stop bit.
    hold_line(1'b1, 16 * BIT_CLKS);
    check("t6_tail_count", pulse_cnt, 9);
    check("t6_tail_ferr", {31'd0, last_err}, 32'd0);
    base_cnt = pulse_cnt;
    hold_line(1'b1, 12 * BIT_CLKS);
    check("t6_idle_quiet", pulse_cnt, base_cnt);
    send_frame(8'h5A, 1'b1);
    hold_line(1'b1, BIT_CLKS);
    check("t6_resume_count", pulse_cnt, base_cnt + 1);
    check("t6_resume_data", {24'd0, last_data}, 32'h5A);
    check("t6_resume_ferr", {31'd0, last_err}, 32'd0);

    check("done_single_cycle", dbl_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
